// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port (if_*)
// and the load/store port (d_*). Data has fixed priority; fetch is granted
// once data has won STARVE_LIMIT consecutive grants while fetch was waiting.
// Only one memory access is outstanding at a time.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch accept, completion pulse, read data
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb             load/store request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata      load/store accept, completion pulse, load data
//                               (d_rdata is 0 when a store completes)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb         memory access, driven from latched fields
//   mem_ready/mem_rdata         memory completion and read data
//
// Optional feature, macro ARB_PERF_EN: adds 32-bit wrapping counters
//   perf_if_grants, perf_d_grants and perf_if_stall (cycles with if_req
//   high but no if_gnt). Arbitration is identical with or without it.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]             perf_if_grants,
    output logic [31:0]             perf_d_grants,
    output logic [31:0]             perf_if_stall
`endif
);

    localparam int STRB_WIDTH   = DATA_WIDTH / 8;
    localparam int STREAK_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = STREAK_WIDTH'(STARVE_LIMIT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_D  = 2'd2;

    logic [1:0]              state;
    logic [STREAK_WIDTH-1:0] streak;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;

    logic busy_if;
    logic busy_d;
    logic accept;
    logic starve;
    logic grant_if;
    logic grant_d;

    assign busy_if = (state == BUSY_IF);
    assign busy_d  = (state == BUSY_D);

    // A new access may start when idle or in the completion cycle of the
    // current one; suppressed during reset so nothing is granted and lost.
    assign accept   = !rst && ((state == IDLE) || mem_ready);
    assign starve   = if_req && (streak == STREAK_MAX);
    assign grant_d  = accept && d_req && !starve;
    assign grant_if = accept && if_req && !grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            streak  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (accept) begin
                if (grant_d) begin
                    state   <= BUSY_D;
                    we_q    <= d_we;
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    wstrb_q <= d_wstrb;
                end else if (grant_if) begin
                    state   <= BUSY_IF;
                    we_q    <= 1'b0;
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    wstrb_q <= '0;
                end else begin
                    state   <= IDLE;
                end
            end

            // streak counts data grants that overtook a waiting fetch
            if (grant_if || !if_req) begin
                streak <= '0;
            end else if (grant_d && (streak != STREAK_MAX)) begin
                streak <= streak + STREAK_WIDTH'(1);
            end
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;

    // Completion is passed straight through in the mem_ready cycle; a
    // reset in that cycle abandons the access without a completion pulse.
    assign if_rvalid = busy_if && mem_ready && !rst;
    assign d_rvalid  = busy_d && mem_ready && !rst;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;

    assign mem_req   = busy_if || busy_d;
    assign mem_we    = busy_d && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = (busy_d && we_q) ? wstrb_q : '0;

`ifdef ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_if_stall  <= '0;
        end else begin
            if (grant_if) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (grant_d) begin
                perf_d_grants <= perf_d_grants + 32'd1;
            end
            if (if_req && !grant_if) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (default parameters). Outputs are
// sampled mid-cycle; the memory returns a fixed function of its address.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [63:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ready;
    logic [63:0] mem_rdata;
`ifdef ARB_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_d_grants;
    logic [31:0] perf_if_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] rd(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_1234, ~a[31:0]};
    endfunction

    assign mem_rdata = rd(mem_addr);

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
`ifdef ARB_PERF_EN
        ,
        .perf_if_grants (perf_if_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_if_stall  (perf_if_stall)
`endif
    );

    // Requesters must hold req until granted.
    a_if_hold: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_gnt) |=> if_req)
        else $error("FAIL if_req_hold: if_req dropped before if_gnt");
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (d_req && !d_gnt) |=> d_req)
        else $error("FAIL d_req_hold: d_req dropped before d_gnt");

    // {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req}
    function automatic logic [4:0] st();
        return {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        if_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        cyc(); cyc();
        #4;
        vectors++;
        if ({st(), mem_we, mem_addr, mem_wdata, mem_wstrb, if_rdata, d_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got st=%b addr=%h wstrb=%h, want all zero",
                     st(), mem_addr, mem_wstrb);
        end
        cyc();
        rst = 1'b0;
        #4;
        vectors++;
        if (st() !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_idle: got %b want 00000", st());
        end
        cyc();
    endtask

    task automatic test_fetch();
        mem_ready = 1'b1;
        if_req = 1'b1; if_addr = 64'h40;
        #4;
        vectors++;
        if (st() !== 5'b10000) begin
            miscompares++;
            $display("FAIL fetch_gnt: got %b want 10000", st());
        end
        cyc();
        if_req = 1'b0; if_addr = 64'h0;
        #4;
        vectors++;
        if ({st(), mem_addr, if_rdata} !== {5'b00101, 64'h40, rd(64'h40)}) begin
            miscompares++;
            $display("FAIL fetch_rvalid: got %b addr=%h data=%h want 00101 addr=40 data=%h",
                     st(), mem_addr, if_rdata, rd(64'h40));
        end
        cyc();
        #4;
        vectors++;
        if ({st(), mem_we, mem_wstrb} !== '0) begin
            miscompares++;
            $display("FAIL fetch_idle: got %b want 00000", st());
        end
        cyc();
    endtask

    task automatic test_priority();
        mem_ready = 1'b1;
        if_req = 1'b1; if_addr = 64'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        #4;
        vectors++;
        if (st() !== 5'b01000) begin
            miscompares++;
            $display("FAIL prio_d_first: got %b want 01000", st());
        end
        cyc();
        d_req = 1'b0;
        #4;
        vectors++;
        if ({st(), mem_addr, d_rdata} !== {5'b10011, 64'h100, rd(64'h100)}) begin
            miscompares++;
            $display("FAIL prio_if_gnt_on_d_done: got %b addr=%h data=%h want 10011 addr=100 data=%h",
                     st(), mem_addr, d_rdata, rd(64'h100));
        end
        cyc();
        if_req = 1'b0;
        #4;
        vectors++;
        if ({st(), mem_addr, if_rdata} !== {5'b00101, 64'h80, rd(64'h80)}) begin
            miscompares++;
            $display("FAIL prio_if_rvalid: got %b addr=%h data=%h want 00101 addr=80 data=%h",
                     st(), mem_addr, if_rdata, rd(64'h80));
        end
        cyc();
    endtask

    task automatic test_starvation();
        logic [4:0] expv [8];
        expv = '{5'b01000, 5'b01011, 5'b01011, 5'b01011,
                 5'b10011, 5'b01101, 5'b00011, 5'b00000};
        mem_ready = 1'b1;
        d_we = 1'b0; d_addr = 64'h300; if_addr = 64'h500;
        for (int k = 0; k < 8; k++) begin
            if_req = (k <= 4);
            d_req  = (k <= 5);
            #4;
            vectors++;
            if (st() !== expv[k]) begin
                miscompares++;
                $display("FAIL starve_cycle%0d: got %b want %b", k, st(), expv[k]);
            end
            cyc();
        end
        // a fresh contention after the fetch was served: data wins again
        if_req = 1'b1; d_req = 1'b1;
        #4;
        vectors++;
        if (st() !== 5'b01000) begin
            miscompares++;
            $display("FAIL starve_streak_cleared: got %b want 01000", st());
        end
        cyc();
        d_req = 1'b0;
        cyc();
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_store_wait();
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200;
        d_wdata = 64'hDEADBEEF; d_wstrb = 8'h0F;
        #4;
        vectors++;
        if (st() !== 5'b01000) begin
            miscompares++;
            $display("FAIL store_gnt: got %b want 01000", st());
        end
        cyc();
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'h999; d_wdata = 64'h1234; d_wstrb = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            #4;
            vectors++;
            if ({st(), mem_we, mem_addr, mem_wdata, mem_wstrb} !==
                {5'b00001, 1'b1, 64'h200, 64'hDEADBEEF, 8'h0F}) begin
                miscompares++;
                $display("FAIL store_stable%0d: got %b we=%b addr=%h wdata=%h wstrb=%h",
                         k, st(), mem_we, mem_addr, mem_wdata, mem_wstrb);
            end
            cyc();
        end
        mem_ready = 1'b1;
        #4;
        vectors++;
        if ({st(), d_rdata} !== {5'b00011, 64'h0}) begin
            miscompares++;
            $display("FAIL store_done: got %b d_rdata=%h want 00011 d_rdata=0", st(), d_rdata);
        end
        cyc();
        #4;
        vectors++;
        if ({st(), mem_we, mem_wstrb} !== '0) begin
            miscompares++;
            $display("FAIL store_idle: got %b we=%b wstrb=%h want all zero",
                     st(), mem_we, mem_wstrb);
        end
        cyc();
    endtask

    task automatic test_reset_busy();
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h180;
        cyc();
        d_req = 1'b0;
        rst = 1'b1;
        #4;
        vectors++;
        if (st() !== 5'b00001) begin
            miscompares++;
            $display("FAIL rstbusy_inflight: got %b want 00001", st());
        end
        cyc();
        rst = 1'b0; mem_ready = 1'b1;
        #4;
        vectors++;
        if ({st(), mem_addr, d_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rstbusy_abandoned: got %b addr=%h want all zero", st(), mem_addr);
        end
        cyc();
        if_req = 1'b1; if_addr = 64'h48;
        #4;
        vectors++;
        if (st() !== 5'b10000) begin
            miscompares++;
            $display("FAIL rstbusy_new_gnt: got %b want 10000", st());
        end
        cyc();
        if_req = 1'b0;
        #4;
        vectors++;
        if ({st(), if_rdata} !== {5'b00101, rd(64'h48)}) begin
            miscompares++;
            $display("FAIL rstbusy_new_rvalid: got %b data=%h want 00101 data=%h",
                     st(), if_rdata, rd(64'h48));
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int          gi;
        logic [63:0] la;
        logic        rdy;
        logic [4:0]  e;
`ifdef ARB_PERF_EN
        logic [31:0] g0, d0, s0;
        g0 = perf_if_grants; d0 = perf_d_grants; s0 = perf_if_stall;
`endif
        gi = 0; la = '0;
        for (int k = 0; k < 17; k++) begin
            rdy = !(k == 3 || k == 4 || k == 5 || k == 8 || k == 9);
            mem_ready = rdy;
            if_req  = (gi < 10);
            if_addr = 64'h1000 + 64'(8 * gi);
            e = {if_req && (k == 0 || rdy), 1'b0, (k > 0 && k < 16) && rdy, 1'b0,
                 (k > 0 && k < 16)};
            #4;
            vectors++;
            if (st() !== e || (e[2] && if_rdata !== rd(la))) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: got %b data=%h want %b data=%h",
                         k, st(), if_rdata, e, rd(la));
            end
            if (e[4]) begin
                la = if_addr;
                gi++;
            end
            cyc();
        end
`ifdef ARB_PERF_EN
        vectors++;
        if ({perf_if_grants - g0, perf_d_grants - d0, perf_if_stall - s0} !==
            {32'd10, 32'd0, 32'd5}) begin
            miscompares++;
            $display("FAIL perf_counts: grants=%0d d=%0d stall=%0d want 10 0 5",
                     perf_if_grants - g0, perf_d_grants - d0, perf_if_stall - s0);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_store_wait();
        test_reset_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
